// File: rtl/serial_frame_deserializer_if.sv
// rtl/serial_frame_deserializer_if.sv - serial input and parallel frame outputs of the deserializer
interface serial_frame_deserializer_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              din;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              sync_locked;
  logic [CNT_W-1:0]  frame_cnt;

  modport master (
    input  din,
    output data_out, data_valid, parity_err, sync_locked, frame_cnt
  );

  modport slave (
    output din,
    input  data_out, data_valid, parity_err, sync_locked, frame_cnt
  );
endinterface

// File: rtl/serial_frame_deserializer.sv
// rtl/serial_frame_deserializer.sv - sync-word hunting serial to parallel frame decoder with even parity
module serial_frame_deserializer #(
  parameter int                SYNC_W       = 8,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = 8'hA5,
  parameter int                DATA_W       = 8,
  parameter int                CNT_W        = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  serial_frame_deserializer_if.master   bus
);
  localparam int FILL_W = $clog2(SYNC_W + 1);
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SYNC_W - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    DATA   = 2'b01,
    PARITY = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [SYNC_W-1:0] sync_q, sync_d, sync_shift;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] pay_q, pay_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              locked_q, locked_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              par_bad;

  assign sync_shift = {sync_q[SYNC_W-2:0], bus.din};
  assign par_bad    = bus.din != (^pay_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HUNT;
      sync_q   <= '0;
      fill_q   <= '0;
      bit_q    <= '0;
      pay_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      fill_q   <= fill_d;
      bit_q    <= bit_d;
      pay_q    <= pay_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      locked_q <= locked_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sync_d  = sync_q;
    fill_d  = fill_q;
    bit_d   = bit_q;
    pay_d   = pay_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      HUNT: begin
        sync_d = sync_shift;
        if (fill_q != FILL_FULL) fill_d = fill_q + FILL_W'(1);
        // Requiring a full window keeps an all-zero pattern from matching the cleared register.
        if (fill_q >= FILL_LAST && sync_shift == SYNC_PATTERN) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        pay_d = DATA_W'({pay_q, bus.din});
        bit_d = bit_q + BIT_W'(1);
        if (bit_q == BIT_LAST) state_d = PARITY;
      end
      PARITY: begin
        data_d  = pay_q;
        err_d   = par_bad;
        valid_d = 1'b1;
        if (!par_bad) cnt_d = cnt_q + CNT_W'(1);
        state_d = HUNT;
        sync_d  = '0;
        fill_d  = '0;
      end
      default: begin
        state_d = HUNT;
        sync_d  = '0;
        fill_d  = '0;
      end
    endcase
  end

  assign locked_d = (state_d == DATA) || (state_d == PARITY);

  assign bus.data_out    = data_q;
  assign bus.data_valid  = valid_q;
  assign bus.parity_err  = err_q;
  assign bus.sync_locked = locked_q;
  assign bus.frame_cnt   = cnt_q;
endmodule

// File: tb/tb_serial_frame_deserializer.sv
// tb/tb_serial_frame_deserializer.sv - scoreboard bench for serial_frame_deserializer
module tb_serial_frame_deserializer;
  localparam logic [7:0] SYNC = 8'hA5;

  typedef struct {
    logic [7:0] data;
    logic       err;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
  } frame_t;

  typedef struct {
    logic valid;
    logic locked;
  } cyc_t;

  logic clk;
  logic rst;
  logic din;

  serial_frame_deserializer_if #(.DATA_W(8), .CNT_W(8)) bus ();
  serial_frame_deserializer_if #(.DATA_W(8), .CNT_W(2)) bus2 ();

  assign bus.din  = din;
  assign bus2.din = din;

  serial_frame_deserializer #(
    .SYNC_W(8), .SYNC_PATTERN(SYNC), .DATA_W(8), .CNT_W(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  serial_frame_deserializer #(
    .SYNC_W(8), .SYNC_PATTERN(SYNC), .DATA_W(8), .CNT_W(2)
  ) dut_c2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     checks   = 0;
  int     failures = 0;
  bit     running  = 0;
  frame_t frm_q[$];
  cyc_t   cyc_q[$];

  // Reference model state: every bit sampled since the last reset.
  bit     bits[$];
  int     hunt_start = 0;
  int     lock_pos   = -1;
  int     good       = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    bits.delete();
    frm_q.delete();
    cyc_q.delete();
    hunt_start = 0;
    lock_pos   = -1;
    good       = 0;
  endtask

  // A frame is the first window of SYNC bits (fully inside the hunt region) equal to SYNC,
  // followed by 8 payload bits and one parity bit; hunting restarts right after.
  task automatic model_step(input bit b);
    int         len;
    logic [7:0] w;
    frame_t     f;
    cyc_t       c;
    bits.push_back(b);
    len     = bits.size();
    c.valid = 1'b0;
    if (lock_pos < 0) begin
      if (len - hunt_start >= 8) begin
        w = '0;
        for (int k = 0; k < 8; k++) w = {w[6:0], bits[len-8+k]};
        if (w == SYNC) lock_pos = len - 1;
      end
    end else if (len - 1 == lock_pos + 9) begin
      w = '0;
      for (int k = 1; k <= 8; k++) w = {w[6:0], bits[lock_pos+k]};
      f.data = w;
      f.err  = ((^w) != b);
      if (!f.err) good++;
      f.cnt8 = 8'(good);
      f.cnt2 = 2'(good);
      frm_q.push_back(f);
      c.valid    = 1'b1;
      lock_pos   = -1;
      hunt_start = len;
    end
    c.locked = (lock_pos >= 0);
    cyc_q.push_back(c);
  endtask

  task automatic drive_bit(input bit b);
    din = b;
    model_step(b);
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) drive_bit(v[i]);
  endtask

  task automatic send_frame(input logic [7:0] payload, input bit par);
    send_bits(SYNC, 8);
    send_bits(payload, 8);
    drive_bit(par);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_data_out", 32'(bus.data_out), 32'h0);
    chk("rst_data_valid", 32'(bus.data_valid), 32'h0);
    chk("rst_parity_err", 32'(bus.parity_err), 32'h0);
    chk("rst_sync_locked", 32'(bus.sync_locked), 32'h0);
    chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'h0);
    chk("rst_frame_cnt_c2", 32'(bus2.frame_cnt), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: one expected cycle record per sampled bit, one frame record per valid pulse.
  frame_t held;
  always begin
    cyc_t   c;
    frame_t f;
    @(posedge clk);
    #1;
    if (rst) begin
      held.data = '0;
      held.err  = 1'b0;
      held.cnt8 = '0;
      held.cnt2 = '0;
    end else if (running) begin
      if (cyc_q.size() == 0) begin
        chk("cycle_queue_empty", 32'(cyc_q.size()), 32'h1);
      end else begin
        c = cyc_q.pop_front();
        chk("data_valid", 32'(bus.data_valid), 32'(c.valid));
        chk("sync_locked", 32'(bus.sync_locked), 32'(c.locked));
        if (bus.data_valid) begin
          if (frm_q.size() == 0) begin
            chk("unexpected_frame", 32'(bus.data_out), 32'hFFFF_FFFF);
          end else begin
            f    = frm_q.pop_front();
            held = f;
          end
        end
        chk("data_out", 32'(bus.data_out), 32'(held.data));
        chk("parity_err", 32'(bus.parity_err), 32'(held.err));
        chk("frame_cnt", 32'(bus.frame_cnt), 32'(held.cnt8));
        chk("frame_cnt_c2", 32'(bus2.frame_cnt), 32'(held.cnt2));
        chk("c2_data_out", 32'(bus2.data_out), 32'(held.data));
      end
    end
  end

  initial begin
    logic [7:0] p;
    rst = 1'b0;
    din = 1'b0;
    held.data = '0;
    held.err  = 1'b0;
    held.cnt8 = '0;
    held.cnt2 = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("init_data_out", 32'(bus.data_out), 32'h0);
    chk("init_data_valid", 32'(bus.data_valid), 32'h0);
    chk("init_sync_locked", 32'(bus.sync_locked), 32'h0);
    chk("init_frame_cnt", 32'(bus.frame_cnt), 32'h0);
    rst     = 1'b0;
    running = 1'b1;

    send_frame(8'h3C, 1'b0);
    send_frame(8'h3C, 1'b1);
    send_frame(8'h3C, 1'b0);
    send_frame(8'h81, 1'b0);
    send_bits(8'h06, 4);
    send_frame(8'hFF, 1'b0);
    send_frame(8'hA5, 1'b0);

    send_bits(SYNC, 8);
    send_bits(8'h3C, 4);
    do_reset();
    send_frame(8'h3C, 1'b0);
    send_frame(8'h3C, 1'b0);
    send_frame(8'h3C, 1'b0);
    send_frame(8'h3C, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int gap;
      gap = $urandom_range(0, 4);
      for (int g = 0; g < gap; g++) drive_bit(1'($urandom_range(0, 1)));
      p = 8'($urandom);
      send_frame(p, (^p) ^ ($urandom_range(0, 4) == 0));
    end

    repeat (4) drive_bit(1'b0);
    running = 1'b0;
    chk("frames_drained", 32'(frm_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
